// File: rtl/uart_tx.sv
// Two-byte register-write UART transmitter.
// Sends {addr, data} as two 8N1 bytes, LSB first, timed by the shared baud tick:
//   byte 1 = {1'b0, data[6:0]}, byte 2 = {1'b1, addr[5:0], data[7]}
// followed by GAP_BITS idle bit periods before tx_ready returns.
module uart_tx #(
  parameter int unsigned BAUD_DIV = 6,
  parameter int unsigned GAP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_clk,
  input  logic [5:0] tx_addr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_done
);

  localparam logic [2:0] TickLast = 3'(BAUD_DIV - 1);
  localparam logic [1:0] GapLast  = (GAP_BITS == 0) ? 2'd0 : 2'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StGap
  } state_e;

  state_e     state_q;
  logic [2:0] tick_q;
  logic [2:0] bit_q;
  logic       byte_q;
  logic [1:0] gap_q;
  logic [5:0] addr_q;
  logic [7:0] data_q;
  logic       tx_q;
  logic       ready_q;
  logic       done_q;

  logic [7:0] cur_byte;
  logic [2:0] bit_nxt;
  logic       wrap;

  // Current byte payload, next bit index, and end-of-bit tick.
  always_comb begin
    cur_byte = byte_q ? {1'b1, addr_q, data_q[7]} : {1'b0, data_q[6:0]};
    bit_nxt  = bit_q + 3'd1;
    wrap     = uart_clk && (tick_q == TickLast);
  end

  // Frame sequencer; every output is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tick_q  <= 3'd0;
      bit_q   <= 3'd0;
      byte_q  <= 1'b0;
      gap_q   <= 2'd0;
      addr_q  <= 6'd0;
      data_q  <= 8'd0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == StIdle) begin
        // Acceptance never launches the start bit itself, even if a tick coincides.
        if (tx_valid && ready_q) begin
          addr_q  <= tx_addr;
          data_q  <= tx_data;
          ready_q <= 1'b0;
          state_q <= StStart;
          tick_q  <= 3'd0;
          bit_q   <= 3'd0;
          byte_q  <= 1'b0;
          gap_q   <= 2'd0;
        end
      end else if (uart_clk) begin
        tick_q <= wrap ? 3'd0 : tick_q + 3'd1;
        unique case (state_q)
          StStart: begin
            // tx still high here means the first tick after acceptance: drop the line
            // and start timing the start bit from this tick.
            if (tx_q) begin
              tx_q   <= 1'b0;
              tick_q <= 3'd0;
            end else if (wrap) begin
              state_q <= StData;
              bit_q   <= 3'd0;
              tx_q    <= cur_byte[0];
            end
          end
          StData: begin
            if (wrap) begin
              if (bit_q == 3'd7) begin
                state_q <= StStop;
                tx_q    <= 1'b1;
              end else begin
                bit_q <= bit_nxt;
                tx_q  <= cur_byte[bit_nxt];
              end
            end
          end
          StStop: begin
            if (wrap) begin
              if (!byte_q) begin
                // Second byte follows immediately, no idle between bytes.
                byte_q  <= 1'b1;
                state_q <= StStart;
                tx_q    <= 1'b0;
              end else if (GAP_BITS == 0) begin
                state_q <= StIdle;
                ready_q <= 1'b1;
                done_q  <= 1'b1;
                tx_q    <= 1'b1;
              end else begin
                state_q <= StGap;
                gap_q   <= 2'd0;
                tx_q    <= 1'b1;
              end
            end
          end
          StGap: begin
            if (wrap) begin
              if (gap_q == GapLast) begin
                state_q <= StIdle;
                ready_q <= 1'b1;
                done_q  <= 1'b1;
              end else begin
                gap_q <= gap_q + 2'd1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: two instances (BAUD_DIV=6/GAP_BITS=1 and 2/0).
// Stimulus pushes hand-computed byte pairs; per-instance monitors decode the line.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       uart_clk;
  logic       tick_en = 1'b1;
  logic [5:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, tx_a, done_a;
  logic       ready_b, tx_b, done_b;

  typedef struct packed {
    logic [7:0] b1;
    logic [7:0] b2;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int unsigned checks = 0;
  int unsigned errors = 0;

  uart_tx #(.BAUD_DIV(6), .GAP_BITS(1)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_clk (uart_clk),
    .tx_addr  (addr_a),
    .tx_data  (data_a),
    .tx_valid (valid_a),
    .tx_ready (ready_a),
    .tx       (tx_a),
    .tx_done  (done_a)
  );

  uart_tx #(.BAUD_DIV(2), .GAP_BITS(0)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_clk (uart_clk),
    .tx_addr  (addr_b),
    .tx_data  (data_b),
    .tx_valid (valid_b),
    .tx_ready (ready_b),
    .tx       (tx_b),
    .tx_done  (done_b)
  );

  // Baud tick: one clk wide every other cycle while enabled, driven on the falling edge.
  initial begin
    uart_clk = 1'b0;
    forever begin
      @(negedge clk);
      uart_clk = tick_en ? ~uart_clk : 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic tx_of(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  function automatic logic ready_of(input bit sel);
    return sel ? ready_b : ready_a;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  function automatic int qsize(input bit sel);
    return sel ? q_b.size() : q_a.size();
  endfunction

  // Decodes one frame per start bit and checks it against the oldest expectation.
  task automatic monitor(input bit sel, input int unsigned bd, input int unsigned gap);
    exp_t        e;
    logic [19:0] fr;
    logic [19:0] rxb;
    logic        exp_bit;
    int unsigned t, last, bad_t, guard;
    bit          aborted;
    string       tag;
    tag = sel ? "b" : "a";
    forever begin
      @(posedge clk); #1;
      if (rst_n !== 1'b1 || tx_of(sel) !== 1'b0) continue;
      if (qsize(sel) == 0) begin
        check({tag, "_unexpected_frame"}, 32'd1, 32'd0);
        guard = 0;
        while (tx_of(sel) === 1'b0 && guard < 10000) begin
          @(posedge clk); #1;
          guard++;
        end
        continue;
      end
      e       = sel ? q_b.pop_front() : q_a.pop_front();
      fr      = {1'b1, e.b2, 1'b0, 1'b1, e.b1, 1'b0};
      last    = (20 + gap) * bd;
      t       = 0;
      bad_t   = 32'hFFFF_FFFF;
      aborted = 1'b0;
      rxb     = '0;
      while (t < last && !aborted) begin
        exp_bit = (t < 20 * bd) ? fr[t / bd] : 1'b1;
        if ((tx_of(sel) !== exp_bit || ready_of(sel) !== 1'b0 || done_of(sel) !== 1'b0) &&
            bad_t == 32'hFFFF_FFFF) bad_t = t;
        if ((t % bd) == (bd / 2) && t < 20 * bd) rxb[t / bd] = tx_of(sel);
        @(posedge clk); #1;
        if (rst_n !== 1'b1) aborted = 1'b1;
        else if (uart_clk === 1'b1) t++;
      end
      if (aborted) begin
        guard = 0;
        while (rst_n !== 1'b1 && guard < 10000) begin
          @(posedge clk);
          guard++;
        end
        continue;
      end
      check({tag, "_line_bad_tick"}, bad_t, 32'hFFFF_FFFF);
      check({tag, "_rx_frame"}, {12'd0, rxb}, {12'd0, fr});
      check({tag, "_done_edge"}, {29'd0, tx_of(sel), ready_of(sel), done_of(sel)}, 32'd7);
    end
  endtask

  initial monitor(1'b0, 6, 1);
  initial monitor(1'b1, 2, 0);

  task automatic wait_ready(input bit sel, input string name);
    int n;
    n = 0;
    while (ready_of(sel) !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_wait"}, {31'd0, (n < 5000)}, 32'd1);
  endtask

  task automatic push_a(input logic [7:0] eb1, input logic [7:0] eb2);
    exp_t e;
    e.b1 = eb1;
    e.b2 = eb2;
    q_a.push_back(e);
  endtask

  // Sends one request on instance A, scrambles inputs after acceptance,
  // and checks the start bit appears on the first tick after acceptance.
  task automatic send_a(input logic [5:0] a, input logic [7:0] d,
                        input logic [7:0] eb1, input logic [7:0] eb2, input string name);
    int n;
    @(negedge clk);
    addr_a  = a;
    data_a  = d;
    valid_a = 1'b1;
    wait_ready(1'b0, name);
    push_a(eb1, eb2);
    @(posedge clk); #1;
    valid_a = 1'b0;
    addr_a  = ~a;
    data_a  = ~d;
    check({name, "_accept"}, {31'd0, ready_a}, 32'd0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (uart_clk !== 1'b1 && n < 100);
    check({name, "_start"}, {31'd0, tx_a}, 32'd0);
  endtask

  initial begin
    exp_t eb;
    int   n, cnt;
    logic frozen;
    bit   ok;

    rst_n   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    addr_a  = 6'd0;
    data_a  = 8'd0;
    addr_b  = 6'd0;
    data_b  = 8'd0;
    repeat (5) @(negedge clk);
    #1;
    check("rst_a", {29'd0, tx_a, ready_a, done_a}, 32'd6);
    check("rst_b", {29'd0, tx_b, ready_b, done_b}, 32'd6);
    @(negedge clk);
    rst_n = 1'b1;

    // 200 ticks idle with no request.
    ok = 1'b1;
    repeat (400) begin
      @(posedge clk); #1;
      if (tx_a !== 1'b1 || ready_a !== 1'b1 || done_a !== 1'b0 ||
          tx_b !== 1'b1 || ready_b !== 1'b1 || done_b !== 1'b0) ok = 1'b0;
    end
    check("idle", {31'd0, ok}, 32'd1);

    // Single frame: bytes 0x23 then 0x8B.
    send_a(6'h05, 8'hA3, 8'h23, 8'h8B, "single");

    // Loopback set.
    send_a(6'h3F, 8'hFF, 8'h7F, 8'hFF, "lb0");
    send_a(6'h00, 8'h00, 8'h00, 8'h80, "lb1");
    send_a(6'h0A, 8'h5A, 8'h5A, 8'h94, "lb2");

    // Busy: request held, inputs changed mid-frame, tick gated to check freeze.
    @(negedge clk);
    addr_a  = 6'h12;
    data_a  = 8'h34;
    valid_a = 1'b1;
    wait_ready(1'b0, "busy");
    push_a(8'h34, 8'hA4);
    @(posedge clk); #1;
    check("busy_accept", {31'd0, ready_a}, 32'd0);
    repeat (101) @(negedge clk);
    addr_a = 6'h21;
    data_a = 8'h43;
    push_a(8'h43, 8'hC2);
    @(posedge clk); #1;
    tick_en = 1'b0;
    @(negedge clk); #1;
    frozen = tx_a;
    ok = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (tx_a !== frozen || uart_clk !== 1'b0) ok = 1'b0;
    end
    check("freeze", {31'd0, ok}, 32'd1);
    tick_en = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (done_a !== 1'b1 && n < 2000);
    check("busy_done", {31'd0, done_a}, 32'd1);
    @(posedge clk); #1;
    check("b2b_accept", {31'd0, ready_a}, 32'd0);
    valid_a = 1'b0;
    wait_ready(1'b0, "b2b");

    // Reset in the middle of byte 2 (frame bit 15 = A3 of 0x24 = 0).
    send_a(6'h24, 8'h99, 8'h19, 8'hC9, "rstf");
    cnt = 0;
    n   = 0;
    while (cnt < 93 && n < 1000) begin
      @(posedge clk); #1;
      if (uart_clk === 1'b1) cnt++;
      n++;
    end
    check("rst_pre", {30'd0, tx_a, ready_a}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", {29'd0, tx_a, ready_a, done_a}, 32'd6);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_a(6'h01, 8'h80, 8'h00, 8'h83, "post_rst");
    wait_ready(1'b0, "post_rst_end");

    // Instance B: request accepted on an edge that carries a tick.
    n = 0;
    @(negedge clk); #1;
    while (uart_clk !== 1'b1 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    addr_b  = 6'h15;
    data_b  = 8'h6E;
    valid_b = 1'b1;
    eb.b1   = 8'h6E;
    eb.b2   = 8'hAA;
    q_b.push_back(eb);
    @(posedge clk); #1;
    valid_b = 1'b0;
    check("b_accept", {30'd0, ready_b, tx_b}, 32'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (uart_clk !== 1'b1 && n < 10);
    check("b_start", {31'd0, tx_b}, 32'd0);
    wait_ready(1'b1, "b_end");

    repeat (4) @(negedge clk);
    check("drain", q_a.size() + q_b.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
